// File: rtl/lcd1602_drv.sv
`default_nettype none
// ============================================================================
// Module   : lcd1602_drv
// Function : HD44780 1602 LCD writer. It runs the power-on init, then refreshes
//            two 16-char rows periodically. Define LCD_4BIT_EN for the nibble bus.
// Revision : 1.0
// ============================================================================
module lcd1602_drv #(
  parameter int unsigned T_POWER   = 750000,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLR     = 100000,
  parameter int unsigned T_REFRESH = 2500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] line0,
  input  logic [127:0] line1,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [7:0]   lcd_d,
  output logic         init_done,
  output logic         frame_done
);
  localparam int unsigned P_POWER   = (T_POWER   == 0) ? 1 : T_POWER;
  localparam int unsigned P_EN      = (T_EN      == 0) ? 1 : T_EN;
  localparam int unsigned P_CMD     = (T_CMD     == 0) ? 1 : T_CMD;
  localparam int unsigned P_CLR     = (T_CLR     == 0) ? 1 : T_CLR;
  localparam int unsigned P_REFRESH = (T_REFRESH == 0) ? 1 : T_REFRESH;
  localparam int unsigned P_MAX_A   = (P_POWER > P_REFRESH) ? P_POWER : P_REFRESH;
  localparam int unsigned P_MAX_B   = (P_CLR > P_CMD) ? P_CLR : P_CMD;
  localparam int unsigned P_MAX_C   = (P_MAX_A > P_MAX_B) ? P_MAX_A : P_MAX_B;
  localparam int unsigned P_MAX     = (P_MAX_C > P_EN) ? P_MAX_C : P_EN;
  localparam int          CW        = $clog2(P_MAX + 1);

  localparam logic [CW-1:0] C_POWER_M1   = CW'(P_POWER - 1);
  localparam logic [CW-1:0] C_EN_M1      = CW'(P_EN - 1);
  localparam logic [CW-1:0] C_CMD_M1     = CW'(P_CMD - 1);
  localparam logic [CW-1:0] C_CLR_M1     = CW'(P_CLR - 1);
  localparam logic [CW-1:0] C_REFRESH_M1 = CW'(P_REFRESH - 1);

`ifdef LCD_4BIT_EN
  localparam logic [3:0] C_ROM_LAST = 4'd8;
`else
  localparam logic [3:0] C_ROM_LAST = 4'd7;
`endif

  typedef enum logic [3:0] {
    PWR_WAIT = 4'd0, INIT = 4'd1, FRAME = 4'd2, ADDR0 = 4'd3,
    ROW0     = 4'd4, ADDR1 = 4'd5, ROW1 = 4'd6, IDLE  = 4'd7
  } state_t;

  typedef enum logic [1:0] {PH_SETUP = 2'd0, PH_STROBE = 2'd1, PH_WAIT = 2'd2} phase_t;

  function automatic logic [7:0] rom_byte(input logic [3:0] i);
    case (i)
`ifdef LCD_4BIT_EN
      4'd0, 4'd1, 4'd2: rom_byte = 8'h30;
      4'd3:             rom_byte = 8'h20;
      4'd4:             rom_byte = 8'h28;
      4'd5:             rom_byte = 8'h08;
      4'd6:             rom_byte = 8'h01;
      4'd7:             rom_byte = 8'h06;
      default:          rom_byte = 8'h0C;
`else
      4'd0, 4'd1, 4'd2: rom_byte = 8'h30;
      4'd3:             rom_byte = 8'h38;
      4'd4:             rom_byte = 8'h08;
      4'd5:             rom_byte = 8'h01;
      4'd6:             rom_byte = 8'h06;
      default:          rom_byte = 8'h0C;
`endif
    endcase
  endfunction

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      col_q, col_d;
  logic [7:0]      byte_q, byte_d;
  logic            rs_q, rs_d;
  logic [7:0]      dat_q, dat_d;
  logic            e_q, e_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;
  logic [127:0]    snap0_q, snap0_d;
  logic [127:0]    snap1_q, snap1_d;
`ifdef LCD_4BIT_EN
  logic            nib_q, nib_d;
  logic            single_q, single_d;
  logic            ld_single;
`endif

  logic            ld;
  logic [7:0]      ld_byte;
  logic            ld_rs;
  logic            done;
  logic [3:0]      col_nx;
  logic [CW-1:0]   wait_m1;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    col_d        = col_q;
    byte_d       = byte_q;
    rs_d         = rs_q;
    dat_d        = dat_q;
    e_d          = e_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    snap0_d      = snap0_q;
    snap1_d      = snap1_q;
    ld           = 1'b0;
    ld_byte      = 8'h00;
    ld_rs        = 1'b0;
    done         = 1'b0;
    col_nx       = col_q + 4'd1;
    wait_m1      = (!rs_q && byte_q == 8'h01) ? C_CLR_M1 : C_CMD_M1;
`ifdef LCD_4BIT_EN
    nib_d        = nib_q;
    single_d     = single_q;
    ld_single    = 1'b0;
`endif

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == C_POWER_M1) begin
          state_d = INIT;
          idx_d   = 4'd0;
          ld      = 1'b1;
          ld_byte = rom_byte(4'd0);
`ifdef LCD_4BIT_EN
          ld_single = 1'b1;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      IDLE: begin
        if (cnt_q == C_REFRESH_M1) begin
          state_d = FRAME;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      FRAME: begin
        snap0_d = line0;
        snap1_d = line1;
        state_d = ADDR0;
        ld      = 1'b1;
        ld_byte = 8'h80;
      end
      default: begin
        // Byte transfer: setup (T_EN), strobe (T_EN), then settle wait.
        case (phase_q)
          PH_SETUP: begin
            if (cnt_q == C_EN_M1) begin
              phase_d = PH_STROBE;
              cnt_d   = '0;
              e_d     = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
          end
          PH_STROBE: begin
            if (cnt_q == C_EN_M1) begin
              e_d   = 1'b0;
              cnt_d = '0;
`ifdef LCD_4BIT_EN
              if (!nib_q && !single_q) begin
                phase_d = PH_SETUP;
                nib_d   = 1'b1;
                dat_d   = {byte_q[3:0], 4'h0};
              end else
`endif
              phase_d = PH_WAIT;
            end else cnt_d = cnt_q + 1'b1;
          end
          default: begin
            if (cnt_q == wait_m1) done = 1'b1;
            else cnt_d = cnt_q + 1'b1;
          end
        endcase

        if (done) begin
          case (state_q)
            INIT: begin
              if (idx_q == C_ROM_LAST) begin
                init_done_d = 1'b1;
                state_d     = FRAME;
                cnt_d       = '0;
              end else begin
                idx_d   = idx_q + 4'd1;
                ld      = 1'b1;
                ld_byte = rom_byte(idx_q + 4'd1);
`ifdef LCD_4BIT_EN
                ld_single = (idx_q + 4'd1) < 4'd4;
`endif
              end
            end
            ADDR0: begin
              state_d = ROW0;
              col_d   = 4'd0;
              ld      = 1'b1;
              ld_rs   = 1'b1;
              ld_byte = snap0_q[127:120];
            end
            ROW0: begin
              ld = 1'b1;
              if (col_q == 4'd15) begin
                state_d = ADDR1;
                ld_byte = 8'hC0;
              end else begin
                col_d   = col_nx;
                ld_rs   = 1'b1;
                ld_byte = snap0_q[{~col_nx, 3'b000} +: 8];
              end
            end
            ADDR1: begin
              state_d = ROW1;
              col_d   = 4'd0;
              ld      = 1'b1;
              ld_rs   = 1'b1;
              ld_byte = snap1_q[127:120];
            end
            default: begin
              if (col_q == 4'd15) begin
                state_d      = IDLE;
                cnt_d        = '0;
                frame_done_d = 1'b1;
              end else begin
                col_d   = col_nx;
                ld      = 1'b1;
                ld_rs   = 1'b1;
                ld_byte = snap1_q[{~col_nx, 3'b000} +: 8];
              end
            end
          endcase
        end
      end
    endcase

    if (ld) begin
      byte_d  = ld_byte;
      rs_d    = ld_rs;
      phase_d = PH_SETUP;
      cnt_d   = '0;
`ifdef LCD_4BIT_EN
      dat_d    = {ld_byte[7:4], 4'h0};
      nib_d    = 1'b0;
      single_d = ld_single;
`else
      dat_d    = ld_byte;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PWR_WAIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      col_q        <= 4'd0;
      byte_q       <= 8'h00;
      rs_q         <= 1'b0;
      dat_q        <= 8'h00;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      snap0_q      <= '0;
      snap1_q      <= '0;
`ifdef LCD_4BIT_EN
      nib_q        <= 1'b0;
      single_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      byte_q       <= byte_d;
      rs_q         <= rs_d;
      dat_q        <= dat_d;
      e_q          <= e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
`ifdef LCD_4BIT_EN
      nib_q        <= nib_d;
      single_q     <= single_d;
`endif
    end
  end

  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign lcd_d      = dat_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd1602_drv
// Function : Self-checking bench for lcd1602_drv (8-bit build): strobe scoreboard.
// Revision : 1.0
// ============================================================================
module tb_lcd1602_drv;
  localparam int T_POWER   = 10;
  localparam int T_EN      = 2;
  localparam int T_CMD     = 5;
  localparam int T_CLR     = 20;
  localparam int T_REFRESH = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] line0 = '0;
  logic [127:0] line1 = '0;
  logic         lcd_rs, lcd_rw, lcd_e;
  logic [7:0]   lcd_d;
  logic         init_done, frame_done;

  lcd1602_drv #(
    .T_POWER(T_POWER), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_REFRESH(T_REFRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line0(line0), .line1(line1),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;   // cycles from previous strobe rise (or from reset release)
  } exp_t;

  exp_t exp_q[$];

  int   total = 0;
  int   bad   = 0;
  logic prev_e = 1'b0, prev_fd = 1'b0, prev_id = 1'b0;
  int   last_rise = 0, rise_cyc = 0, fd_cnt = 0, fd_cyc = 0;
  logic fd_valid = 1'b0;
  logic [7:0] rise_d = 8'h00;
  logic [127:0] txt0, blank, xs;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      prev_e = 1'b0; prev_fd = 1'b0; prev_id = 1'b0;
      last_rise = 0; fd_valid = 1'b0;
    end else begin
      if (lcd_e && !prev_e) begin
        rise_cyc = cyc;
        rise_d   = lcd_d;
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", {24'h0, lcd_d}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_d", {24'h0, lcd_d}, {24'h0, e.d});
          chk("strobe_rs", {31'h0, lcd_rs}, {31'h0, e.rs});
          chk("strobe_gap", cyc - last_rise, e.gap);
          if (fd_valid && !e.rs && e.d == 8'h80) chk("refresh_gap", cyc - fd_cyc, 53);
        end
        last_rise = cyc;
      end
      if (!lcd_e && prev_e) begin
        chk("e_width", cyc - rise_cyc, T_EN);
        chk("d_hold", {24'h0, lcd_d}, {24'h0, rise_d});
      end
      if (frame_done) begin
        if (prev_fd) chk("fd_width", 2, 1);
        else begin
          fd_cnt++;
          fd_cyc   = cyc;
          fd_valid = 1'b1;
          chk("fd_time", cyc - last_rise, 7);
        end
      end
      if (init_done && !prev_id) chk("init_done_time", cyc - last_rise, 7);
      prev_e  = lcd_e;
      prev_fd = frame_done;
      prev_id = init_done;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_size(input int n, input string name);
    int k;
    k = 0;
    while (exp_q.size() > n && k < 2000) begin
      tick();
      k++;
    end
    if (exp_q.size() > n) chk(name, exp_q.size(), n);
  endtask

  task automatic wait_fd(input int n, input string name);
    int k;
    k = 0;
    while (fd_cnt < n && k < 2000) begin
      tick();
      k++;
    end
    chk(name, fd_cnt, n);
  endtask

  task automatic push_frame(input logic [127:0] a, input logic [127:0] b, input int first_gap);
    exp_q.push_back('{1'b0, 8'h80, first_gap});
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, a[127-8*i -: 8], 9});
    exp_q.push_back('{1'b0, 8'hC0, 9});
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, b[127-8*i -: 8], 9});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rs"}, {31'h0, lcd_rs}, 0);
    chk({tag, "_rw"}, {31'h0, lcd_rw}, 0);
    chk({tag, "_e"}, {31'h0, lcd_e}, 0);
    chk({tag, "_d"}, {24'h0, lcd_d}, 0);
    chk({tag, "_init_done"}, {31'h0, init_done}, 0);
    chk({tag, "_frame_done"}, {31'h0, frame_done}, 0);
  endtask

  initial begin
    exp_t init_tbl[8];
    int   k;
    init_tbl[0] = '{1'b0, 8'h30, 12};
    init_tbl[1] = '{1'b0, 8'h30, 9};
    init_tbl[2] = '{1'b0, 8'h30, 9};
    init_tbl[3] = '{1'b0, 8'h38, 9};
    init_tbl[4] = '{1'b0, 8'h08, 9};
    init_tbl[5] = '{1'b0, 8'h01, 9};
    init_tbl[6] = '{1'b0, 8'h06, 24};
    init_tbl[7] = '{1'b0, 8'h0C, 9};

    txt0  = "23.11.2123:59:30";
    blank = {16{8'h20}};
    xs    = {16{8'h58}};
    line0 = txt0;
    line1 = blank;

    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");

    for (int i = 0; i < 8; i++) exp_q.push_back(init_tbl[i]);
    push_frame(txt0, blank, 10);
    rst_n = 1'b1;
    wait_size(0, "frame1_timeout");
    wait_fd(1, "frame1_done_count");
    chk("init_done_high", {31'h0, init_done}, 1);

    // Second frame: change line0 while row 0 is being written.
    push_frame(txt0, blank, 60);
    wait_size(30, "frame2_row0_timeout");
    line0 = xs;
    wait_size(0, "frame2_timeout");
    wait_fd(2, "frame2_done_count");

    // Third frame shows the new text; reset it mid row 1 with lcd_e high.
    push_frame(xs, blank, 60);
    wait_size(11, "frame3_row1_timeout");
    chk("e_high_mid_row1", {31'h0, lcd_e}, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    repeat (3) tick();

    for (int i = 0; i < 8; i++) exp_q.push_back(init_tbl[i]);
    rst_n = 1'b1;
    wait_size(0, "reinit_timeout");
    k = 0;
    while (!init_done && k < 200) begin
      tick();
      k++;
    end
    chk("reinit_done", {31'h0, init_done}, 1);
    chk("no_fd_after_reset", fd_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
